// File: rtl/tile_pkg.sv
// Shared definitions for the tile operation sequencer: widths, opcodes, FSM states,
// instruction field positions and flag vector bit order.
package tile_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned INSTR_W = 16;
   localparam int unsigned NREG    = 4;
   localparam int unsigned RIDX_W  = 2;
   localparam int unsigned OP_W    = 4;
   localparam int unsigned FLAG_W  = 5;
   localparam int unsigned RSVD_W  = 5;

   localparam logic [OP_W-1:0] OP_ADD = 4'd0;
   localparam logic [OP_W-1:0] OP_MUL = 4'd1;
   localparam logic [OP_W-1:0] OP_SUB = 4'd2;
   localparam logic [OP_W-1:0] OP_SLL = 4'd3;
   localparam logic [OP_W-1:0] OP_SRL = 4'd4;
   localparam logic [OP_W-1:0] OP_SRA = 4'd5;
   localparam logic [OP_W-1:0] OP_AND = 4'd6;
   localparam logic [OP_W-1:0] OP_OR  = 4'd7;
   localparam logic [OP_W-1:0] OP_NOT = 4'd8;
   localparam logic [OP_W-1:0] OP_XOR = 4'd9;
   localparam logic [OP_W-1:0] OP_CMP = 4'd10;

   // Instruction word field positions
   localparam int unsigned OP_LSB   = 0;
   localparam int unsigned DST_LSB  = 4;
   localparam int unsigned SRCA_LSB = 6;
   localparam int unsigned SRCB_LSB = 8;
   localparam int unsigned RSVD_LSB = 10;
   localparam int unsigned HALT_BIT = 15;

   // Flag vector bit order: {carry, overflow, lessthan, equalto, zero}
   localparam int unsigned FLG_ZERO     = 0;
   localparam int unsigned FLG_EQUAL    = 1;
   localparam int unsigned FLG_LESS     = 2;
   localparam int unsigned FLG_OVERFLOW = 3;
   localparam int unsigned FLG_CARRY    = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   function automatic logic op_writes_reg(input logic [OP_W-1:0] op);
      return op <= OP_XOR;
   endfunction

   function automatic logic op_writes_flags(input logic [OP_W-1:0] op);
      return op <= OP_CMP;
   endfunction

endpackage

// File: rtl/tile_op_sequencer_if.sv
// Configuration, status and ALU-side signals of the tile operation sequencer.
interface tile_op_sequencer_if
   import tile_pkg::*;
#(
   parameter int unsigned DEPTH = 16
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic                 cfg_we;
   logic [AW-1:0]        cfg_addr;
   logic [INSTR_W-1:0]   cfg_data;
   logic                 reg_we;
   logic [RIDX_W-1:0]    reg_addr;
   logic [DATA_W-1:0]    reg_wdata;
   logic                 start;
   logic                 abort;
   logic                 busy;
   logic                 done;
   logic [DATA_W-1:0]    result;
   logic [FLAG_W-1:0]    flags;
   logic [DATA_W-1:0]    alu_a;
   logic [DATA_W-1:0]    alu_b;
   logic [OP_W-1:0]      alu_control;
   logic [DATA_W-1:0]    alu_s;
   logic                 alu_carry;
   logic                 alu_overflow;
   logic                 alu_lessthan;
   logic                 alu_equalto;
   logic                 alu_zero;

   modport master (
      output cfg_we, cfg_addr, cfg_data, reg_we, reg_addr, reg_wdata, start, abort,
      output alu_s, alu_carry, alu_overflow, alu_lessthan, alu_equalto, alu_zero,
      input  busy, done, result, flags, alu_a, alu_b, alu_control
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_data, reg_we, reg_addr, reg_wdata, start, abort,
      input  alu_s, alu_carry, alu_overflow, alu_lessthan, alu_equalto, alu_zero,
      output busy, done, result, flags, alu_a, alu_b, alu_control
   );

endinterface

// File: rtl/tile_instr_mem.sv
// Program store: synchronous write, registered read. Array contents are not reset.
module tile_instr_mem #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_re,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [WIDTH-1:0]         o_rdata
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Read register holds the fetched word for the whole EXEC cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/tile_op_sequencer.sv
// Fetches ALU micro-instructions from the program store, drives the ALU operands
// and writes results/flags back into a 4-entry register file.
module tile_op_sequencer
   import tile_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   tile_op_sequencer_if.slave  io_bus
);
   localparam int unsigned AW = $clog2(DEPTH);

   state_e               r_state;
   logic [AW-1:0]        r_pc;
   logic [DATA_W-1:0]    r_regs [NREG];
   logic [FLAG_W-1:0]    r_flags;
   logic                 r_busy;
   logic                 r_done;

   logic [INSTR_W-1:0]   w_instr;
   logic [OP_W-1:0]      w_op;
   logic [RIDX_W-1:0]    w_dst;
   logic [RIDX_W-1:0]    w_srca;
   logic [RIDX_W-1:0]    w_srcb;
   logic                 w_halt;
   logic                 w_last;
   logic                 w_exec;
   logic                 w_cfg_we;
   logic [FLAG_W-1:0]    w_alu_flags;
   logic                 w_unused_rsvd;

   assign w_cfg_we = (r_state == ST_IDLE) && !io_bus.abort && io_bus.cfg_we;

   tile_instr_mem #(
      .DEPTH (DEPTH),
      .WIDTH (INSTR_W)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_cfg_we),
      .i_waddr (io_bus.cfg_addr),
      .i_wdata (io_bus.cfg_data),
      .i_re    (r_state == ST_FETCH),
      .i_raddr (r_pc),
      .o_rdata (w_instr)
   );

   assign w_op          = w_instr[OP_LSB   +: OP_W];
   assign w_dst         = w_instr[DST_LSB  +: RIDX_W];
   assign w_srca        = w_instr[SRCA_LSB +: RIDX_W];
   assign w_srcb        = w_instr[SRCB_LSB +: RIDX_W];
   assign w_halt        = w_instr[HALT_BIT];
   assign w_unused_rsvd = ^w_instr[RSVD_LSB +: RSVD_W];
   assign w_last        = (r_pc == AW'(DEPTH - 1));
   assign w_exec        = (r_state == ST_EXEC);

   assign w_alu_flags[FLG_CARRY]    = io_bus.alu_carry;
   assign w_alu_flags[FLG_OVERFLOW] = io_bus.alu_overflow;
   assign w_alu_flags[FLG_LESS]     = io_bus.alu_lessthan;
   assign w_alu_flags[FLG_EQUAL]    = io_bus.alu_equalto;
   assign w_alu_flags[FLG_ZERO]     = io_bus.alu_zero;

   // ALU idles on ADD 0+0 outside EXEC
   assign io_bus.alu_a       = w_exec ? r_regs[w_srca] : '0;
   assign io_bus.alu_b       = w_exec ? r_regs[w_srcb] : '0;
   assign io_bus.alu_control = w_exec ? w_op : '0;

   assign io_bus.result = r_regs[0];
   assign io_bus.flags  = r_flags;
   assign io_bus.busy   = r_busy;
   assign io_bus.done   = r_done;

   // Sequencer FSM, register file and flag latch; abort overrides every write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_pc    <= '0;
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
         r_flags <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (io_bus.abort) begin
         r_state <= ST_IDLE;
         r_pc    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (io_bus.reg_we) r_regs[io_bus.reg_addr] <= io_bus.reg_wdata;
               if (io_bus.start) begin
                  r_state <= ST_FETCH;
                  r_pc    <= '0;
                  r_busy  <= 1'b1;
               end
            end
            ST_FETCH: r_state <= ST_EXEC;
            ST_EXEC: begin
               if (op_writes_reg(w_op))   r_regs[w_dst] <= io_bus.alu_s;
               if (op_writes_flags(w_op)) r_flags       <= w_alu_flags;
               if (w_halt || w_last) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= ST_FETCH;
                  r_pc    <= r_pc + AW'(1);
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
